// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: imem req/gnt/rvalid front end feeding decode through a credit-limited FIFO.
// Define FETCH_BYPASS_EN to forward a response to decode in the same cycle when the FIFO is empty.
module unidad_busqueda #(
  parameter int unsigned        SIZE_PC  = 32,
  parameter int unsigned        SIZE_INS = 32,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [SIZE_PC-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [SIZE_PC-1:0]  imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [SIZE_INS-1:0] imem_rdata,
  output logic [SIZE_INS-1:0] instruccion,
  output logic [SIZE_PC-1:0]  pc_out,
  output logic                ins_valid,
  input  logic                ins_ready,
  input  logic                Branch,
  input  logic                Zero,
  input  logic                Jump,
  input  logic [SIZE_PC-1:0]  target_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
`ifdef FETCH_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [SIZE_PC-1:0]  pc_q, pc_d;
  logic [CW-1:0]       out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0]       rd_q, rd_d, wr_q, wr_d, trd_q, trd_d, twr_q, twr_d;
  logic [SIZE_INS-1:0] ins_mem_q [DEPTH];
  logic [SIZE_INS-1:0] ins_mem_d [DEPTH];
  logic [SIZE_PC-1:0]  pc_mem_q  [DEPTH];
  logic [SIZE_PC-1:0]  pc_mem_d  [DEPTH];
  logic [SIZE_PC-1:0]  tag_q     [DEPTH];
  logic [SIZE_PC-1:0]  tag_d     [DEPTH];

  logic grant, rsp, redirect, head_valid, keep, byp, push, pop;

  assign imem_req  = req_q;
  assign imem_addr = pc_q;

  always_comb begin
    grant      = req_q & imem_gnt;
    rsp        = imem_rvalid & (out_q != '0);
    redirect   = (Branch & Zero) | Jump;
    head_valid = (cnt_q != '0);
    // A response is kept only in S_RUN and loses to a same-cycle redirect.
    keep       = rsp & ~redirect & (state_q == S_RUN);
    byp        = BYPASS_EN & keep & ~head_valid;
    push       = keep & ~(byp & ins_ready);
    pop        = head_valid & ins_ready;

    ins_valid   = head_valid | byp;
    instruccion = '0;
    pc_out      = '0;
    if (head_valid) begin
      instruccion = ins_mem_q[rd_q];
      pc_out      = pc_mem_q[rd_q];
    end else if (byp) begin
      instruccion = imem_rdata;
      pc_out      = tag_q[trd_q];
    end

    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    trd_d    = trd_q;
    twr_d    = twr_q;
    ins_mem_d = ins_mem_q;
    pc_mem_d  = pc_mem_q;
    tag_d     = tag_q;

    if (grant) begin
      tag_d[twr_q] = pc_q;
      twr_d        = twr_q + AW'(1);
      pc_d         = pc_q + SIZE_PC'(4);
    end
    if (rsp) trd_d = trd_q + AW'(1);
    out_d = out_q + CW'(grant) - CW'(rsp);

    if (push) begin
      ins_mem_d[wr_q] = imem_rdata;
      pc_mem_d[wr_q]  = tag_q[trd_q];
      wr_d            = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    case (state_q)
      S_INIT:  state_d = S_RUN;
      S_DRAIN: if (rsp && drop_q != '0) begin
        drop_d = drop_q - CW'(1);
        if (drop_q == CW'(1)) state_d = S_RUN;
      end
      default: ;
    endcase

    // Drop count covers this cycle's grant/response so later rvalids line up.
    if (redirect) begin
      pc_d = {target_pc[SIZE_PC-1:2], 2'b00};
      if (state_q != S_DRAIN) begin
        cnt_d   = '0;
        rd_d    = '0;
        wr_d    = '0;
        drop_d  = out_d;
        state_d = (out_d != '0) ? S_DRAIN : S_RUN;
      end
    end

    req_d = (state_d == S_RUN) && (({1'b0, out_d} + {1'b0, cnt_d}) < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      trd_q   <= '0;
      twr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
        tag_q[i]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pc_q      <= pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      trd_q     <= trd_d;
      twr_q     <= twr_d;
      ins_mem_q <= ins_mem_d;
      pc_mem_q  <= pc_mem_d;
      tag_q     <= tag_d;
    end
  end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Scoreboard bench for unidad_busqueda: directed phases push expected PCs, a monitor checks each decode transfer.
module tb_unidad_busqueda;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruccion;
  logic [31:0] pc_out;
  logic        ins_valid;
  logic        ins_ready;
  logic        Branch, Zero, Jump;
  logic [31:0] target_pc;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend[$];
  int          gnt_budget = 0;
  bit          rsp_en = 1'b1;
  int          grant_cnt = 0;
  logic [31:0] mon_e;

  always #5 clk = ~clk;

  assign imem_gnt = (gnt_budget != 0);

  unidad_busqueda #(
    .SIZE_PC (32),
    .SIZE_INS(32),
    .DEPTH   (2),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instruccion(instruccion),
    .pc_out     (pc_out),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .Branch     (Branch),
    .Zero       (Zero),
    .Jump       (Jump),
    .target_pc  (target_pc)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[15:0], 16'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_empty(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cycle();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_budget(input string name, input int max);
    int n = 0;
    while (gnt_budget != 0 && n < max) begin
      cycle();
      n++;
    end
    check(name, 32'(gnt_budget), 32'd0);
  endtask

  // Memory: records grants, returns in order from the cycle after each grant.
  initial begin
    logic        g;
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      g = imem_req & imem_gnt;
      a = imem_addr;
      @(posedge clk);
      #1;
      if (g) begin
        pend.push_back(a);
        grant_cnt++;
        if (gnt_budget > 0) gnt_budget--;
      end
      if (rsp_en && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ins_valid === 1'b1 && ins_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery: got pc %h expected none", pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("pc_out", pc_out, mon_e);
        check("instruccion", instruccion, word(mon_e));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    rst_n = 1'b0;
    ins_ready = 1'b1;
    Branch = 1'b0;
    Zero = 1'b0;
    Jump = 1'b0;
    target_pc = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(ins_valid), 32'd0);
    check("rst_ins", instruccion, 32'h0);
    check("rst_pc", pc_out, 32'h0);

    // Sequential fetch 0..28
    cycle();
    rst_n = 1'b1;
    gnt_budget = 8;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    check("init_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #2;
    check("first_req", 32'(imem_req), 32'd1);
    wait_empty("seq_drain", 80);

    // Back-pressure: only DEPTH requests while decode stalls
    ins_ready = 1'b0;
    g0 = grant_cnt;
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h24);
    gnt_budget = 100;
    repeat (10) cycle();
    check("stall_grants", 32'(grant_cnt - g0), 32'd2);
    check("stall_req", 32'(imem_req), 32'd0);
    gnt_budget = 0;
    ins_ready = 1'b1;
    wait_empty("stall_drain", 20);

    // Taken branch with two in flight
    rsp_en = 1'b0;
    gnt_budget = 2;
    wait_budget("br_grants", 20);
    Branch = 1'b1;
    Zero = 1'b1;
    target_pc = 32'h100;
    cycle();
    Branch = 1'b0;
    Zero = 1'b0;
    target_pc = '0;
    check("br_addr", imem_addr, 32'h100);
    check("br_req", 32'(imem_req), 32'd0);
    check("br_valid", 32'(ins_valid), 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    gnt_budget = 2;
    rsp_en = 1'b1;
    wait_empty("br_drain", 40);

    // Not-taken branch, then misaligned jump
    Branch = 1'b1;
    Zero = 1'b0;
    target_pc = 32'h300;
    cycle();
    Branch = 1'b0;
    check("nt_addr", imem_addr, 32'h108);
    Jump = 1'b1;
    target_pc = 32'h203;
    cycle();
    Jump = 1'b0;
    target_pc = '0;
    check("jmp_addr", imem_addr, 32'h200);
    exp_q.push_back(32'h200);
    gnt_budget = 1;
    wait_empty("jmp_drain", 20);

    // PC wrap
    Jump = 1'b1;
    target_pc = 32'hFFFF_FFFC;
    cycle();
    Jump = 1'b0;
    target_pc = '0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    gnt_budget = 2;
    wait_empty("wrap_drain", 30);
    check("wrap_addr1", imem_addr, 32'h4);

    // Reset with two requests in flight
    rsp_en = 1'b0;
    gnt_budget = 2;
    wait_budget("rr_grants", 20);
    rst_n = 1'b0;
    #1;
    check("rr_req", 32'(imem_req), 32'd0);
    check("rr_addr", imem_addr, 32'h0);
    check("rr_valid", 32'(ins_valid), 32'd0);
    check("rr_ins", instruccion, 32'h0);
    check("rr_pc", pc_out, 32'h0);
    cycle();
    rst_n = 1'b1;
    rsp_en = 1'b1;
    repeat (4) cycle();
    check("rr_stale_valid", 32'(ins_valid), 32'd0);
    check("rr_restart_addr", imem_addr, 32'h0);
    check("rr_restart_req", 32'(imem_req), 32'd1);
    exp_q.push_back(32'h0);
    gnt_budget = 1;
    wait_empty("rr_drain", 20);

    repeat (3) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
